// File: rtl/neureka_package.sv
// Shared constants, index-width helpers and the per-port operation record
// used by the TCDM responder and its banks.
package neureka_package;

    // Cycles from grant edge to response valid.
    localparam int unsigned NEUREKA_TCDM_RESP_LATENCY = 1;

    // Width of an index selecting one of n items (never less than one bit).
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Per-port operation as seen by a bank: wen = 1 is a read.
    typedef struct packed {
        logic        wen;
        logic [3:0]  be;
        logic [31:0] data;
    } tcdm_op_t;

endpackage

// File: rtl/neureka_tcdm_bank.sv
// One word-interleaved bank: round-robin arbiter over all ports, storage
// array with byte-enable writes, and a registered read word.
module neureka_tcdm_bank
    import neureka_package::*;
#(
    parameter int unsigned MP         = 4,
    parameter int unsigned BANK_DEPTH = 256,
    localparam int unsigned PORT_W    = idx_width(MP),
    localparam int unsigned ROW_W     = idx_width(BANK_DEPTH)
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [MP-1:0]              req,
    input  logic [MP-1:0][ROW_W-1:0]   row,
    input  tcdm_op_t [MP-1:0]          op,
    output logic [MP-1:0]              gnt,
    output logic [31:0]                r_data
);

    logic [PORT_W-1:0] ptr_q, ptr_d;
    logic [PORT_W-1:0] win;
    logic              found;
    logic [ROW_W-1:0]  win_row;
    tcdm_op_t          win_op;
    logic [31:0]       mem [BANK_DEPTH];

    // Pick the first requester at or after the pointer, wrapping; the
    // pointer only moves past the winner when someone actually lost.
    always_comb begin
        int idx;
        int n_req;
        idx     = 0;
        n_req   = 0;
        win     = '0;
        found   = 1'b0;
        gnt     = '0;
        ptr_d   = ptr_q;
        for (int k = 0; k < int'(MP); k++) begin
            idx = (int'(ptr_q) + k) % int'(MP);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = PORT_W'(idx);
            end
            n_req += int'(req[k]);
        end
        if (found) gnt[win] = 1'b1;
        if (n_req >= 2) ptr_d = (win == PORT_W'(MP - 1)) ? '0 : win + 1'b1;
        win_row = row[win];
        win_op  = op[win];
    end

    // Round-robin pointer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) ptr_q <= '0;
        else         ptr_q <= ptr_d;
    end

    // Storage: not reset; accesses in a reset cycle are dropped.
    always_ff @(posedge clk_i) begin
        if (rst_ni && found) begin
            if (win_op.wen) begin
                r_data <= mem[win_row];
            end else begin
                for (int b = 0; b < 4; b++)
                    if (win_op.be[b]) mem[win_row][8*b +: 8] <= win_op.data[8*b +: 8];
            end
        end
    end

endmodule

// File: rtl/neureka_tcdm_responder.sv
// Multi-port TCDM target: decodes each port's address onto N_BANKS
// interleaved banks, grants one port per bank per cycle, and returns a
// response one cycle after every grant. Out-of-range accesses are granted
// immediately, never touch memory, and respond with zero data and r_opc.
module neureka_tcdm_responder
    import neureka_package::*;
#(
    parameter int unsigned MP         = 4,
    parameter int unsigned N_BANKS    = 8,
    parameter int unsigned BANK_DEPTH = 256,
    parameter logic [31:0] BASE_ADDR  = 32'h1C00_0000
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [MP-1:0]         tcdm_req,
    output logic [MP-1:0]         tcdm_gnt,
    input  logic [MP-1:0][31:0]   tcdm_add,
    input  logic [MP-1:0]         tcdm_wen,
    input  logic [MP-1:0][3:0]    tcdm_be,
    input  logic [MP-1:0][31:0]   tcdm_data,
    output logic [MP-1:0][31:0]   tcdm_r_data,
    output logic [MP-1:0]         tcdm_r_valid,
    output logic                  tcdm_r_opc
);

    localparam int unsigned BANK_W = idx_width(N_BANKS);
    localparam int unsigned ROW_W  = idx_width(BANK_DEPTH);
    localparam int unsigned BANK_SH = $clog2(N_BANKS);
    localparam logic [29:0] BANK_MASK = 30'(N_BANKS - 1);
    localparam logic [31:0] N_WORDS = 32'(N_BANKS * BANK_DEPTH);
    localparam int unsigned STAGES = NEUREKA_TCDM_RESP_LATENCY;

    logic [MP-1:0][29:0]          word;
    logic [MP-1:0]                oor;
    logic [MP-1:0][BANK_W-1:0]    bank_idx;
    logic [MP-1:0][ROW_W-1:0]     row_idx;
    tcdm_op_t [MP-1:0]            port_op;
    logic [N_BANKS-1:0][MP-1:0]   bank_req;
    logic [N_BANKS-1:0][MP-1:0]   bank_gnt;
    logic [N_BANKS-1:0][31:0]     bank_rdata;

    logic [STAGES:1][MP-1:0]      vld_pipe;
    logic [MP-1:0]                rsp_rd;
    logic [MP-1:0]                rsp_oor;
    logic [MP-1:0][BANK_W-1:0]    rsp_bank;

    // Address decode and steering of in-range requests to their bank.
    always_comb begin
        logic [31:0] off;
        off      = '0;
        word     = '0;
        oor      = '0;
        bank_idx = '0;
        row_idx  = '0;
        port_op  = '0;
        bank_req = '0;
        for (int i = 0; i < int'(MP); i++) begin
            off         = tcdm_add[i] - BASE_ADDR;
            word[i]     = off[31:2];
            oor[i]      = (tcdm_add[i] < BASE_ADDR) || ({2'b00, word[i]} >= N_WORDS);
            bank_idx[i] = BANK_W'(word[i] & BANK_MASK);
            row_idx[i]  = ROW_W'(word[i] >> BANK_SH);
            port_op[i]  = '{wen: tcdm_wen[i], be: tcdm_be[i], data: tcdm_data[i]};
            if (tcdm_req[i] && !oor[i]) bank_req[bank_idx[i]][i] = 1'b1;
        end
    end

    for (genvar b = 0; b < int'(N_BANKS); b++) begin : g_bank
        neureka_tcdm_bank #(
            .MP         (MP),
            .BANK_DEPTH (BANK_DEPTH)
        ) i_bank (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .req    (bank_req[b]),
            .row    (row_idx),
            .op     (port_op),
            .gnt    (bank_gnt[b]),
            .r_data (bank_rdata[b])
        );
    end

    // A port is granted by its bank, or at once when out of range.
    always_comb begin
        tcdm_gnt = '0;
        for (int i = 0; i < int'(MP); i++) begin
            for (int b = 0; b < int'(N_BANKS); b++)
                tcdm_gnt[i] = tcdm_gnt[i] | bank_gnt[b][i];
            tcdm_gnt[i] = tcdm_req[i] & (tcdm_gnt[i] | oor[i]);
        end
    end

    // Response tracking: valid shift register plus per-port sideband
    // captured at the grant edge (single stage, matching the bank read).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_pipe <= '0;
            rsp_rd   <= '0;
            rsp_oor  <= '0;
            rsp_bank <= '0;
        end else begin
            vld_pipe[1] <= tcdm_gnt;
            for (int s = 2; s <= int'(STAGES); s++) vld_pipe[s] <= vld_pipe[s-1];
            rsp_rd   <= tcdm_wen;
            rsp_oor  <= oor;
            rsp_bank <= bank_idx;
        end
    end

    // Response outputs: read data only for valid in-range reads.
    always_comb begin
        tcdm_r_valid = vld_pipe[STAGES];
        tcdm_r_opc   = |(vld_pipe[STAGES] & rsp_oor);
        tcdm_r_data  = '0;
        for (int i = 0; i < int'(MP); i++)
            if (vld_pipe[STAGES][i] && rsp_rd[i] && !rsp_oor[i])
                tcdm_r_data[i] = bank_rdata[rsp_bank[i]];
    end

endmodule

// File: tb/tb_neureka_tcdm_responder.sv
// Directed bench with scoreboard: each expected grant pushes the
// hand-computed response into a per-port queue; a negedge monitor pops
// and compares whenever the DUT presents r_valid.
module tb_neureka_tcdm_responder;

    localparam int MP = 4;
    localparam int NB = 8;
    localparam int BD = 256;
    localparam logic [31:0] BASE = 32'h1C00_0000;

    logic                 clk_i = 1'b0;
    logic                 rst_ni = 1'b0;
    logic [MP-1:0]        tcdm_req = '0;
    logic [MP-1:0]        tcdm_gnt;
    logic [MP-1:0][31:0]  tcdm_add = '0;
    logic [MP-1:0]        tcdm_wen = '1;
    logic [MP-1:0][3:0]   tcdm_be = '0;
    logic [MP-1:0][31:0]  tcdm_data = '0;
    logic [MP-1:0][31:0]  tcdm_r_data;
    logic [MP-1:0]        tcdm_r_valid;
    logic                 tcdm_r_opc;

    always #5 clk_i = ~clk_i;

    neureka_tcdm_responder #(
        .MP(MP), .N_BANKS(NB), .BANK_DEPTH(BD), .BASE_ADDR(BASE)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .tcdm_req(tcdm_req), .tcdm_gnt(tcdm_gnt), .tcdm_add(tcdm_add),
        .tcdm_wen(tcdm_wen), .tcdm_be(tcdm_be), .tcdm_data(tcdm_data),
        .tcdm_r_data(tcdm_r_data), .tcdm_r_valid(tcdm_r_valid), .tcdm_r_opc(tcdm_r_opc)
    );

    typedef struct { logic [31:0] data; logic opc; } exp_t;
    exp_t        exp_q [MP][$];
    logic [31:0] e_data [MP];
    logic        e_opc  [MP];
    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Load one port's request and its hand-computed response.
    task automatic setp(input int p, input logic [31:0] add, input logic wen,
                        input logic [3:0] be, input logic [31:0] data,
                        input logic [31:0] ed, input logic eo);
        tcdm_add[p]  = add;
        tcdm_wen[p]  = wen;
        tcdm_be[p]   = be;
        tcdm_data[p] = data;
        e_data[p]    = ed;
        e_opc[p]     = eo;
    endtask

    // Called at posedge+1: drive req, check grant, queue expected responses.
    task automatic step(input string nm, input logic [MP-1:0] req, input logic [MP-1:0] exp_gnt);
        exp_t e;
        tcdm_req = req;
        #2;
        chk({nm, "_gnt"}, 128'(tcdm_gnt), 128'(exp_gnt));
        for (int p = 0; p < MP; p++)
            if (exp_gnt[p]) begin
                e.data = e_data[p];
                e.opc  = e_opc[p];
                exp_q[p].push_back(e);
            end
        @(posedge clk_i);
        #1;
    endtask

    // Response monitor.
    always @(negedge clk_i) begin : mon
        exp_t e;
        logic eo;
        logic any;
        if (rst_ni) begin
            eo  = 1'b0;
            any = 1'b0;
            for (int p = 0; p < MP; p++) begin
                if (tcdm_r_valid[p]) begin
                    any = 1'b1;
                    if (exp_q[p].size() == 0) begin
                        chk($sformatf("unexpected_rvalid_p%0d", p), 128'(1), 128'(0));
                    end else begin
                        e = exp_q[p].pop_front();
                        eo = eo | e.opc;
                        chk($sformatf("rdata_p%0d", p), 128'(tcdm_r_data[p]), 128'(e.data));
                    end
                end
            end
            if (any) chk("r_opc", 128'(tcdm_r_opc), 128'(eo));
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        #3;
        chk("rst_rvalid", 128'(tcdm_r_valid), 128'(0));
        chk("rst_opc",    128'(tcdm_r_opc),   128'(0));
        chk("rst_rdata",  128'(tcdm_r_data),  128'(0));
        @(posedge clk_i); @(posedge clk_i); #1;
        rst_ni = 1'b1;

        // Populate banks 0..3 row 0 in one conflict-free cycle, then bank 7 row 255
        setp(0, BASE + 32'h0, 1'b0, 4'hF, 32'h1111_0000, 32'h0, 1'b0);
        setp(1, BASE + 32'h4, 1'b0, 4'hF, 32'h2222_1111, 32'h0, 1'b0);
        setp(2, BASE + 32'h8, 1'b0, 4'hF, 32'h3333_2222, 32'h0, 1'b0);
        setp(3, BASE + 32'hC, 1'b0, 4'hF, 32'h4444_3333, 32'h0, 1'b0);
        step("wr4", 4'b1111, 4'b1111);
        setp(0, BASE + 32'h1FFC, 1'b0, 4'hF, 32'h5A5A_5A5A, 32'h0, 1'b0);
        step("wr_top", 4'b0001, 4'b0001);

        // Conflict-free reads
        setp(0, BASE + 32'h0, 1'b1, 4'h0, 32'h0, 32'h1111_0000, 1'b0);
        setp(1, BASE + 32'h4, 1'b1, 4'h0, 32'h0, 32'h2222_1111, 1'b0);
        setp(2, BASE + 32'h8, 1'b1, 4'h0, 32'h0, 32'h3333_2222, 1'b0);
        setp(3, BASE + 32'hC, 1'b1, 4'h0, 32'h0, 32'h4444_3333, 1'b0);
        step("rd4", 4'b1111, 4'b1111);
        chk("rd4_rvalid", 128'(tcdm_r_valid), 128'(4'hF));

        // Full conflict on bank 0, then pointer advance/hold patterns
        for (int p = 0; p < MP; p++) setp(p, BASE, 1'b1, 4'h0, 32'h0, 32'h1111_0000, 1'b0);
        step("conf0", 4'b1111, 4'b0001);
        step("conf1", 4'b1111, 4'b0010);
        step("conf2", 4'b1111, 4'b0100);
        step("conf3", 4'b1111, 4'b1000);
        step("rr_a",  4'b0110, 4'b0010);
        step("rr_b",  4'b0110, 4'b0100);
        step("rr_single", 4'b0010, 4'b0010);
        step("rr_wrap", 4'b0101, 4'b0001);
        step("rr_next", 4'b0101, 4'b0100);

        // Byte enables and write-then-read visibility
        setp(1, BASE + 32'h20, 1'b0, 4'hF, 32'hDEAD_BEEF, 32'h0, 1'b0);
        step("be_full", 4'b0010, 4'b0010);
        setp(1, BASE + 32'h20, 1'b0, 4'h1, 32'h0000_0011, 32'h0, 1'b0);
        step("be_low", 4'b0010, 4'b0010);
        setp(1, BASE + 32'h20, 1'b0, 4'h0, 32'hFFFF_FFFF, 32'h0, 1'b0);
        step("be_none", 4'b0010, 4'b0010);
        setp(1, BASE + 32'h20, 1'b1, 4'h0, 32'h0, 32'hDEAD_BE11, 1'b0);
        step("be_rd", 4'b0010, 4'b0010);

        // Out-of-range: below base, past end, and alongside in-range traffic
        setp(2, BASE - 32'h4, 1'b0, 4'hF, 32'hFFFF_FFFF, 32'h0, 1'b1);
        step("oor_wr", 4'b0100, 4'b0100);
        setp(3, BASE + 32'h2000, 1'b1, 4'h0, 32'h0, 32'h0, 1'b1);
        step("oor_rd", 4'b1000, 4'b1000);
        setp(0, BASE + 32'h0, 1'b1, 4'h0, 32'h0, 32'h1111_0000, 1'b0);
        setp(1, BASE + 32'h2000, 1'b1, 4'h0, 32'h0, 32'h0, 1'b1);
        step("oor_alias", 4'b0011, 4'b0011);
        setp(0, BASE + 32'h1FFC, 1'b1, 4'h0, 32'h0, 32'h5A5A_5A5A, 1'b0);
        step("oor_unchanged", 4'b0001, 4'b0001);
        setp(0, BASE + 32'h0, 1'b1, 4'h0, 32'h0, 32'h1111_0000, 1'b0);
        step("oor_unchanged0", 4'b0001, 4'b0001);

        // Reset while four reads are granted
        setp(0, BASE + 32'h0, 1'b1, 4'h0, 32'h0, 32'h0, 1'b0);
        setp(1, BASE + 32'h4, 1'b1, 4'h0, 32'h0, 32'h0, 1'b0);
        setp(2, BASE + 32'h8, 1'b1, 4'h0, 32'h0, 32'h0, 1'b0);
        setp(3, BASE + 32'hC, 1'b1, 4'h0, 32'h0, 32'h0, 1'b0);
        tcdm_req = 4'b1111;
        #2;
        chk("rstburst_gnt", 128'(tcdm_gnt), 128'(4'hF));
        #3;
        rst_ni = 1'b0;
        @(posedge clk_i); #1;
        chk("rstburst_rvalid", 128'(tcdm_r_valid), 128'(0));
        chk("rstburst_opc",    128'(tcdm_r_opc),   128'(0));
        chk("rstburst_rdata",  128'(tcdm_r_data),  128'(0));
        tcdm_req = '0;
        rst_ni   = 1'b1;
        setp(1, BASE + 32'h20, 1'b1, 4'h0, 32'h0, 32'hDEAD_BE11, 1'b0);
        step("post_rst_rd", 4'b0010, 4'b0010);
        setp(2, BASE + 32'h8, 1'b1, 4'h0, 32'h0, 32'h3333_2222, 1'b0);
        step("post_rst_rd2", 4'b0100, 4'b0100);

        // Drain
        step("idle0", 4'b0000, 4'b0000);
        step("idle1", 4'b0000, 4'b0000);
        chk("drain", 128'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size()), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
